// File: rtl/game_control.sv
// Game flow controller: IDLE/SHOP/READY/BATTLE/RESULT/GAMEOVER/VICTORY.
// Optional battle watchdog enabled by macro GAME_CONTROL_TIMEOUT_EN.
module game_control #(
  parameter int WIN_ROUNDS     = 10,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       chosenDelay2,
  input  logic       actionFight,
  input  logic       battleDone,
  input  logic       battleWin,
  input  logic       alive,
  input  logic [1:0] lives,
  input  logic [7:0] round,
  output logic [2:0] ns,
  output logic [2:0] ps,
  output logic       load_regs,
  output logic       decr_lives,
  output logic       rewards
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHOP     = 3'd1,
    READY    = 3'd2,
    BATTLE   = 3'd3,
    RESULT   = 3'd4,
    GAMEOVER = 3'd5,
    VICTORY  = 3'd6
  } state_t;

  localparam logic [7:0] LAST_ROUND = 8'(WIN_ROUNDS - 1);

  state_t state_q;
  state_t state_d;
  logic   wd_hit;
  logic   force_loss;

`ifdef GAME_CONTROL_TIMEOUT_EN
  logic [9:0] wd_cnt;
  logic       to_loss_q;

  assign wd_hit     = (state_q == BATTLE) &&
                      (wd_cnt >= 10'(TIMEOUT_CYCLES - 1));
  assign force_loss = to_loss_q;

  // Watchdog counts cycles spent in BATTLE; zero outside it.
  always_ff @(posedge clk) begin
    if (reset || state_q != BATTLE) wd_cnt <= '0;
    else                            wd_cnt <= wd_cnt + 10'd1;
  end

  // Remember that RESULT was reached by timeout so it scores a loss.
  always_ff @(posedge clk) begin
    if (reset) to_loss_q <= 1'b0;
    else       to_loss_q <= wd_hit && alive && !battleDone;
  end
`else
  assign wd_hit     = 1'b0;
  assign force_loss = 1'b0;
`endif

  // Present-state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and Mealy command pulses.
  always_comb begin
    state_d    = state_q;
    load_regs  = 1'b0;
    decr_lives = 1'b0;
    rewards    = 1'b0;
    if (reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        SHOP: begin
          if (!alive)            state_d = GAMEOVER;
          else if (chosenDelay2) state_d = READY;
        end
        READY: begin
          if (!alive)           state_d = GAMEOVER;
          else if (actionFight) state_d = BATTLE;
        end
        BATTLE: begin
          if (!alive)          state_d = GAMEOVER;
          else if (battleDone) state_d = RESULT;
          else if (wd_hit)     state_d = RESULT;
        end
        RESULT: begin
          if (battleWin && !force_loss) begin
            rewards = 1'b1;
            state_d = (round == LAST_ROUND) ? VICTORY : SHOP;
          end else begin
            decr_lives = 1'b1;
            state_d    = (lives <= 2'd1) ? GAMEOVER : SHOP;
          end
        end
        GAMEOVER, VICTORY: begin
          if (start) begin
            load_regs = 1'b1;
            state_d   = SHOP;
          end
        end
        default: begin
          if (start) begin
            load_regs = 1'b1;
            state_d   = SHOP;
          end else begin
            state_d = IDLE;
          end
        end
      endcase
    end
  end

  assign ns = state_d;
  assign ps = state_q;

endmodule

// File: tb/tb_game_control.sv
// Directed-vector bench for game_control.
// Expected values are hand-derived from the state table.
module tb_game_control;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       chosenDelay2;
  logic       actionFight;
  logic       battleDone;
  logic       battleWin;
  logic       alive;
  logic [1:0] lives;
  logic [7:0] round;
  logic [2:0] ns;
  logic [2:0] ps;
  logic       load_regs;
  logic       decr_lives;
  logic       rewards;

  int n_vec = 0;
  int n_bad = 0;

  game_control #(
    .WIN_ROUNDS    (10),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .chosenDelay2(chosenDelay2),
    .actionFight (actionFight),
    .battleDone  (battleDone),
    .battleWin   (battleWin),
    .alive       (alive),
    .lives       (lives),
    .round       (round),
    .ns          (ns),
    .ps          (ps),
    .load_regs   (load_regs),
    .decr_lives  (decr_lives),
    .rewards     (rewards)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input string tag,
                        input logic l, input logic d,
                        input logic r);
    chk({tag, ".load"}, {7'd0, load_regs}, {7'd0, l});
    chk({tag, ".decr"}, {7'd0, decr_lives}, {7'd0, d});
    chk({tag, ".rew"}, {7'd0, rewards}, {7'd0, r});
  endtask

  task automatic to_battle();
    chosenDelay2 = 1'b1; tick(); chosenDelay2 = 1'b0;
    actionFight  = 1'b1; tick(); actionFight  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; chosenDelay2 = 1'b0;
    actionFight = 1'b0; battleDone = 1'b0; battleWin = 1'b0;
    alive = 1'b1; lives = 2'd3; round = 8'd0;
    tick(); tick();
    chk("rst.ps", 8'(ps), 8'd0);
    start = 1'b1; #1;
    chk("rst.ns", 8'(ns), 8'd0);
    pulses("rst", 1'b0, 1'b0, 1'b0);
    start = 1'b0; reset = 1'b0; #1;

    // start from IDLE
    start = 1'b1; #1;
    chk("idle.ns", 8'(ns), 8'd1);
    pulses("idle", 1'b1, 1'b0, 1'b0);
    tick(); start = 1'b0; #1;
    chk("shop.ps", 8'(ps), 8'd1);
    pulses("shop", 1'b0, 1'b0, 1'b0);

    // normal winning round
    chosenDelay2 = 1'b1; tick(); chosenDelay2 = 1'b0;
    chk("ready.ps", 8'(ps), 8'd2);
    start = 1'b1; #1;
    chk("ready.start.ns", 8'(ns), 8'd2);
    pulses("ready.start", 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    actionFight = 1'b1; tick(); actionFight = 1'b0;
    chk("battle.ps", 8'(ps), 8'd3);
    round = 8'd3; battleWin = 1'b1; battleDone = 1'b1;
    tick(); battleDone = 1'b0; #1;
    chk("win.ps", 8'(ps), 8'd4);
    chk("win.ns", 8'(ns), 8'd1);
    pulses("win", 1'b0, 1'b0, 1'b1);
    tick();
    chk("win.back", 8'(ps), 8'd1);
    pulses("win.after", 1'b0, 1'b0, 1'b0);

    // loss with one life left
    to_battle();
    battleWin = 1'b0; lives = 2'd1; battleDone = 1'b1;
    tick(); battleDone = 1'b0; #1;
    chk("loss.ns", 8'(ns), 8'd5);
    pulses("loss", 1'b0, 1'b1, 1'b0);
    tick();
    chk("over.ps", 8'(ps), 8'd5);
    pulses("over", 1'b0, 1'b0, 1'b0);
    start = 1'b1; #1;
    pulses("over.start", 1'b1, 1'b0, 1'b0);
    tick(); start = 1'b0;
    chk("restart.ps", 8'(ps), 8'd1);

    // RESULT decode sweep
    lives = 2'd3;
    to_battle();
    battleDone = 1'b1; tick(); battleDone = 1'b0;
    chk("res.ps", 8'(ps), 8'd4);
    battleWin = 1'b1; round = 8'd200; #1;
    chk("res.r200.ns", 8'(ns), 8'd1);
    pulses("res.r200", 1'b0, 1'b0, 1'b1);
    round = 8'd10; #1;
    chk("res.r10.ns", 8'(ns), 8'd1);
    battleWin = 1'b0; lives = 2'd0; #1;
    chk("res.l0.ns", 8'(ns), 8'd5);
    pulses("res.l0", 1'b0, 1'b1, 1'b0);
    lives = 2'd2; alive = 1'b0; #1;
    chk("res.dead.ns", 8'(ns), 8'd1);
    pulses("res.dead", 1'b0, 1'b1, 1'b0);
    alive = 1'b1;
    battleWin = 1'b1; round = 8'd9; #1;
    chk("vic.ns", 8'(ns), 8'd6);
    pulses("vic", 1'b0, 1'b0, 1'b1);
    tick();
    chk("vic.ps", 8'(ps), 8'd6);
    pulses("vic.hold", 1'b0, 1'b0, 1'b0);
    start = 1'b1; #1;
    pulses("vic.start", 1'b1, 1'b0, 1'b0);
    tick(); start = 1'b0;
    chk("vic.restart", 8'(ps), 8'd1);

    // alive=0 overrides actionFight in READY
    round = 8'd0; battleWin = 1'b0;
    chosenDelay2 = 1'b1; tick(); chosenDelay2 = 1'b0;
    actionFight = 1'b1; alive = 1'b0; #1;
    chk("prio.ns", 8'(ns), 8'd5);
    pulses("prio", 1'b0, 1'b0, 1'b0);
    tick(); actionFight = 1'b0; alive = 1'b1;
    chk("prio.ps", 8'(ps), 8'd5);
    start = 1'b1; tick(); start = 1'b0;

    // watchdog / indefinite wait
    to_battle();
    battleWin = 1'b1;
    for (int i = 0; i < 8; i++) tick();
`ifdef GAME_CONTROL_TIMEOUT_EN
    chk("wd.ps", 8'(ps), 8'd4);
    pulses("wd", 1'b0, 1'b1, 1'b0);
    chk("wd.ns", 8'(ns), 8'd1);
`else
    chk("wd.ps", 8'(ps), 8'd3);
    pulses("wd", 1'b0, 1'b0, 1'b0);
    chk("wd.ns", 8'(ns), 8'd3);
`endif

    // reset mid-flight
    reset = 1'b1; start = 1'b1; battleDone = 1'b1; #1;
    chk("mid.rst.ns", 8'(ns), 8'd0);
    pulses("mid.rst", 1'b0, 1'b0, 1'b0);
    tick();
    chk("mid.rst.ps", 8'(ps), 8'd0);
    reset = 1'b0; start = 1'b0; battleDone = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/game_control.md
GAME_CONTROL -- requirements
Module: game_control

Interface
REQ-001 SHALL have parameter WIN_ROUNDS, default 10; number of battle wins that ends the game in victory.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1023; battle watchdog limit, used only with GAME_CONTROL_TIMEOUT_EN.
REQ-003 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  start/restart request from the datapath (key0).
REQ-006 SHALL have port chosenDelay2  input  1  pet selection confirmed by the datapath.
REQ-007 SHALL have port actionFight  input  1  fight request from the datapath (key2).
REQ-008 SHALL have port battleDone, battleWin  input  1 each  battle finished; result valid while battleDone=1.
REQ-009 SHALL have port alive  input  1  player still has a living pet.
REQ-010 SHALL have port lives  input  2  remaining lives, unsigned.
REQ-011 SHALL have port round  input  8  completed-win count, unsigned.
REQ-012 SHALL have port ns  output  3  combinational next-state code, driven to the datapath.
REQ-013 SHALL have port ps  output  3  registered present-state code.
REQ-014 SHALL have ports load_regs, decr_lives, rewards  output  1 each  single-cycle datapath commands.

Function
REQ-015 State encoding SHALL be IDLE=0, SHOP=1, READY=2, BATTLE=3, RESULT=4, GAMEOVER=5, VICTORY=6; code 7 is unused and SHALL behave as IDLE.
REQ-016 ps SHALL load ns every clock edge; ns, load_regs, decr_lives and rewards SHALL be combinational (Mealy) from ps and the inputs.
REQ-017 IDLE: start=1 -> SHOP, with load_regs=1 in the same cycle; otherwise stay.
REQ-018 SHOP: chosenDelay2=1 -> READY; otherwise stay.
REQ-019 READY: actionFight=1 -> BATTLE; otherwise stay.
REQ-020 BATTLE: battleDone=1 -> RESULT; otherwise stay.
REQ-021 RESULT, battleWin=1: rewards=1 for that cycle; if round==WIN_ROUNDS-1 -> VICTORY, else -> SHOP.
REQ-022 RESULT, battleWin=0: decr_lives=1 for that cycle; if lives<=1 -> GAMEOVER, else -> SHOP.
REQ-023 GAMEOVER, VICTORY: start=1 -> SHOP with load_regs=1; otherwise stay.
REQ-024 In SHOP, READY or BATTLE, alive=0 SHALL force ns=GAMEOVER; this overrides every other transition in the same cycle, and no command pulse is asserted.
REQ-025 In RESULT, alive is ignored.
REQ-026 At most one of load_regs, decr_lives, rewards SHALL be high in any cycle; each SHALL be high for exactly one cycle per qualifying transition.
REQ-027 start, actionFight and chosenDelay2 held high SHALL NOT cause repeated commands outside the states that consume them.
REQ-028 lives=0 in RESULT with a loss SHALL go to GAMEOVER; there is no underflow path.
REQ-029 round compare SHALL be unsigned, 8-bit; round>=WIN_ROUNDS in RESULT with a win SHALL go to SHOP, never wrap.

Reset
REQ-030 With reset=1 at a clock edge, ps SHALL become IDLE regardless of state, including mid-BATTLE and mid-RESULT.
REQ-031 While reset=1, ns SHALL read IDLE and load_regs, decr_lives and rewards SHALL be 0.
REQ-032 The watchdog counter SHALL clear to 0 on reset.

Configuration
REQ-033 The battle watchdog SHALL be controlled by macro GAME_CONTROL_TIMEOUT_EN.
REQ-034 With GAME_CONTROL_TIMEOUT_EN defined, the watchdog SHALL work as follows:
- a 10-bit counter clears on BATTLE entry and increments each cycle in BATTLE;
- when it reaches TIMEOUT_CYCLES without battleDone, ns=RESULT and that RESULT is treated as a loss;
- battleDone on the same cycle takes precedence over the timeout.
REQ-035 Without GAME_CONTROL_TIMEOUT_EN, no counter SHALL exist and BATTLE waits indefinitely for battleDone.

Verification
REQ-036 Reset then start=1 for 1 cycle -> load_regs=1 in that cycle, ps=1 next cycle.
REQ-037 Normal round: from SHOP, chosenDelay2=1 -> ps=2; actionFight=1 -> ps=3; battleDone=1, battleWin=1, round=3 -> ps=4, rewards=1 for one cycle, then ps=1.
REQ-038 Loss path: RESULT with battleWin=0 and lives=1 -> decr_lives=1, then ps=5; then start=1 -> load_regs=1, ps=1.
REQ-039 Victory: RESULT with battleWin=1 and round=9 (WIN_ROUNDS=10) -> rewards=1, then ps=6.
REQ-040 Priority: in READY, actionFight=1 and alive=0 together -> ps=5 and no pulse; separately, reset=1 asserted in BATTLE -> ps=0 and all pulses 0.
REQ-041 With GAME_CONTROL_TIMEOUT_EN and TIMEOUT_CYCLES=8: BATTLE with battleDone=0 -> ps=4 after 8 cycles, then decr_lives=1. Without the macro, ps stays 3.
